// File: rtl/vga_frame_reader_if.sv
// Bus bundle between the frame reader and its neighbours: VGA read port,
// pipeline write stream, ZBT pad signals and the swap status.
interface vga_frame_reader_if #(
   parameter int LOG_MEM  = 36,
   parameter int LOG_ADDR = 19
);
   logic                frame_flag;
   logic                vga_flag;
   logic [9:0]          hcount;
   logic [9:0]          vcount;
   logic [LOG_MEM-1:0]  vga_pixel;
   logic                done_vga;
   // wr_* handshake: a word transfers on a rising edge where wr_valid and
   // wr_ready are both high; wr_x/wr_y/wr_data must be stable while wr_valid
   // is high, and wr_ready never depends combinationally on wr_valid.
   logic                wr_valid;
   logic                wr_ready;
   logic [8:0]          wr_x;
   logic [8:0]          wr_y;
   logic [LOG_MEM-1:0]  wr_data;
   logic [LOG_ADDR-1:0] mem_addr;
   logic                mem_we_b;
   logic [LOG_MEM-1:0]  mem_dout;
   logic                mem_dout_en;
   logic [LOG_MEM-1:0]  mem_din;
   logic                display_bank;
   logic                swap_pending;

   modport master (
      output frame_flag, vga_flag, hcount, vcount, wr_valid, wr_x, wr_y, wr_data, mem_din,
      input  vga_pixel, done_vga, wr_ready, mem_addr, mem_we_b, mem_dout, mem_dout_en,
             display_bank, swap_pending
   );

   modport slave (
      input  frame_flag, vga_flag, hcount, vcount, wr_valid, wr_x, wr_y, wr_data, mem_din,
      output vga_pixel, done_vga, wr_ready, mem_addr, mem_we_b, mem_dout, mem_dout_en,
             display_bank, swap_pending
   );
endinterface

// File: rtl/vga_frame_reader.sv
// ZBT arbiter with fixed-latency VGA reads, a buffered back-buffer write path
// and a front/back buffer swap that waits for the start of the next frame.
module vga_frame_reader #(
   parameter int LOG_MEM     = 36,
   parameter int LOG_ADDR    = 19,
   parameter int WFIFO_DEPTH = 8
) (
   input logic               clock,
   input logic               reset_b,
   vga_frame_reader_if.slave bus
);
   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int FW = LOG_MEM + 18;

   typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

   swap_state_t        r_state;
   swap_state_t        w_state_next;
   logic               r_bank;
   logic [FW-1:0]      r_fifo [WFIFO_DEPTH];
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [PW:0]        r_count;
   logic               r_rv1;
   logic               r_rv2;
   logic               r_wv1;
   logic               r_wv2;
   logic [LOG_MEM-1:0] r_wd1;
   logic [LOG_MEM-1:0] r_wd2;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_rd_grant;
   logic               w_wr_issue;
   logic               w_swap_fire;
   logic               w_bank_now;
   logic [FW-1:0]      w_head;
   logic [8:0]         w_head_x;
   logic [8:0]         w_head_y;
   logic [LOG_MEM-1:0] w_head_data;
   logic               w_unused_bits;

   assign w_unused_bits = ^{bus.hcount[0], bus.vcount[9]};

   assign w_full  = (r_count == (PW+1)'(WFIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.wr_valid & bus.wr_ready;

   // Reads always win; the reset gate keeps the address bus at zero while held.
   assign w_rd_grant = bus.vga_flag & reset_b;
   assign w_wr_issue = ~bus.vga_flag & ~w_empty;

   assign w_head      = r_fifo[r_rptr];
   assign w_head_y    = w_head[FW-1 -: 9];
   assign w_head_x    = w_head[FW-10 -: 9];
   assign w_head_data = w_head[LOG_MEM-1:0];

   // The swapping read already addresses the new front buffer.
   assign w_bank_now = r_bank ^ w_swap_fire;

   always_comb begin
      w_state_next = r_state;
      w_swap_fire  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.frame_flag) w_state_next = S_PENDING;
         end
         S_PENDING: begin
            if (w_rd_grant && bus.hcount == 10'd0 && bus.vcount == 10'd0 &&
                w_empty && !r_wv1 && !r_wv2) begin
               w_swap_fire  = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_state <= S_IDLE;
         r_bank  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_bank  <= w_bank_now;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_fifo[r_wptr] <= {bus.wr_y, bus.wr_x, bus.wr_data};
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)     r_wptr <= r_wptr + PW'(1);
         if (w_wr_issue) r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_wr_issue})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Read and write return pipelines; data is zeroed when its valid is low.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_rv1 <= 1'b0;
         r_rv2 <= 1'b0;
         r_wv1 <= 1'b0;
         r_wv2 <= 1'b0;
         r_wd1 <= '0;
         r_wd2 <= '0;
      end else begin
         r_rv1 <= w_rd_grant;
         r_rv2 <= r_rv1;
         r_wv1 <= w_wr_issue;
         r_wv2 <= r_wv1;
         r_wd1 <= w_wr_issue ? w_head_data : '0;
         r_wd2 <= r_wd1;
      end
   end

   always_comb begin
      bus.mem_addr = '0;
      if (w_rd_grant)
         bus.mem_addr = LOG_ADDR'({w_bank_now, bus.vcount[8:0], bus.hcount[9:1]});
      else if (w_wr_issue)
         bus.mem_addr = LOG_ADDR'({~r_bank, w_head_y, w_head_x});
   end

   assign bus.mem_we_b     = ~w_wr_issue;
   assign bus.mem_dout     = r_wd2;
   assign bus.mem_dout_en  = r_wv2;
   assign bus.done_vga     = r_rv2;
   assign bus.vga_pixel    = r_rv2 ? bus.mem_din : '0;
   assign bus.wr_ready     = ~w_full & (r_state != S_PENDING);
   assign bus.display_bank = w_bank_now;
   assign bus.swap_pending = (r_state == S_PENDING);
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: read latency, write arbitration,
// FIFO backpressure and ordering, buffer swap and asynchronous reset.
module tb_vga_frame_reader;
   logic clock = 1'b0;
   logic reset_b;
   int   checks   = 0;
   int   failures = 0;

   logic [18:0] exp_q[$];
   logic [35:0] exp_data_q[$];

   always #5 clock = ~clock;

   vga_frame_reader_if #(.LOG_MEM(36), .LOG_ADDR(19)) bus ();

   vga_frame_reader #(.LOG_MEM(36), .LOG_ADDR(19), .WFIFO_DEPTH(8)) dut (
      .clock  (clock),
      .reset_b(reset_b),
      .bus    (bus)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic idle_inputs;
      bus.frame_flag = 1'b0;
      bus.vga_flag   = 1'b0;
      bus.hcount     = 10'd0;
      bus.vcount     = 10'd0;
      bus.wr_valid   = 1'b0;
      bus.wr_x       = 9'd0;
      bus.wr_y       = 9'd0;
      bus.wr_data    = 36'd0;
      bus.mem_din    = 36'h123456789;
   endtask

   task automatic test_reset;
      reset_b = 1'b0;
      idle_inputs();
      bus.vga_flag = 1'b1;
      bus.hcount   = 10'd6;
      #3;
      checks++; if (bus.done_vga !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done_vga); end
      checks++; if (bus.vga_pixel !== 36'd0) begin failures++; $display("FAIL rst_pixel got=%h exp=0", bus.vga_pixel); end
      checks++; if (bus.mem_addr !== 19'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
      checks++; if (bus.mem_we_b !== 1'b1) begin failures++; $display("FAIL rst_we_b got=%b exp=1", bus.mem_we_b); end
      checks++; if (bus.mem_dout_en !== 1'b0 || bus.mem_dout !== 36'd0) begin failures++; $display("FAIL rst_dout got en=%b d=%h exp en=0 d=0", bus.mem_dout_en, bus.mem_dout); end
      checks++; if (bus.display_bank !== 1'b0) begin failures++; $display("FAIL rst_bank got=%b exp=0", bus.display_bank); end
      checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%b exp=1", bus.wr_ready); end
      tick();
      tick();
      reset_b = 1'b1;
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_read_latency;
      logic [18:0] e;
      e = {1'b0, 9'd2, 9'd3};
      bus.vga_flag = 1'b1; bus.hcount = 10'd6; bus.vcount = 10'd2;
      settle();
      checks++; if (bus.mem_addr !== e) begin failures++; $display("FAIL rd_addr got=%h exp=%h", bus.mem_addr, e); end
      checks++; if (bus.mem_we_b !== 1'b1) begin failures++; $display("FAIL rd_we_b got=%b exp=1", bus.mem_we_b); end
      tick();
      bus.vga_flag = 1'b0;
      settle();
      checks++; if (bus.done_vga !== 1'b0 || bus.vga_pixel !== 36'd0) begin failures++; $display("FAIL rd_t1 got done=%b pix=%h exp done=0 pix=0", bus.done_vga, bus.vga_pixel); end
      tick();
      checks++; if (bus.done_vga !== 1'b1) begin failures++; $display("FAIL rd_t2_done got=%b exp=1", bus.done_vga); end
      checks++; if (bus.vga_pixel !== 36'h123456789) begin failures++; $display("FAIL rd_t2_pixel got=%h exp=123456789", bus.vga_pixel); end
      tick();
      checks++; if (bus.done_vga !== 1'b0 || bus.vga_pixel !== 36'd0) begin failures++; $display("FAIL rd_t3 got done=%b pix=%h exp done=0 pix=0", bus.done_vga, bus.vga_pixel); end
   endtask

   task automatic test_write_priority;
      logic [18:0] e;
      tick();
      bus.vga_flag = 1'b0; bus.wr_valid = 1'b1;
      bus.wr_x = 9'd5; bus.wr_y = 9'd7; bus.wr_data = 36'hABC;
      settle();
      checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL wp_ready got=%b exp=1", bus.wr_ready); end
      checks++; if (bus.mem_we_b !== 1'b1) begin failures++; $display("FAIL wp_no_same_cycle got we_b=%b exp=1", bus.mem_we_b); end
      tick();
      bus.wr_valid = 1'b0; bus.vga_flag = 1'b1; bus.hcount = 10'd8; bus.vcount = 10'd1;
      settle();
      e = {1'b0, 9'd1, 9'd4};
      checks++; if (bus.mem_we_b !== 1'b1 || bus.mem_addr !== e) begin failures++; $display("FAIL wp_read_prio got we_b=%b addr=%h exp we_b=1 addr=%h", bus.mem_we_b, bus.mem_addr, e); end
      tick();
      bus.vga_flag = 1'b0;
      settle();
      e = {1'b1, 9'd7, 9'd5};
      checks++; if (bus.mem_we_b !== 1'b0 || bus.mem_addr !== e) begin failures++; $display("FAIL wp_issue got we_b=%b addr=%h exp we_b=0 addr=%h", bus.mem_we_b, bus.mem_addr, e); end
      tick();
      bus.vga_flag = 1'b1;
      settle();
      checks++; if (bus.mem_dout_en !== 1'b0) begin failures++; $display("FAIL wp_t1_en got=%b exp=0", bus.mem_dout_en); end
      tick();
      bus.vga_flag = 1'b0;
      settle();
      checks++; if (bus.mem_dout_en !== 1'b1 || bus.mem_dout !== 36'hABC) begin failures++; $display("FAIL wp_t2_data got en=%b d=%h exp en=1 d=abc", bus.mem_dout_en, bus.mem_dout); end
      checks++; if (bus.mem_we_b !== 1'b1) begin failures++; $display("FAIL wp_no_extra got we_b=%b exp=1", bus.mem_we_b); end
      tick();
      checks++; if (bus.mem_dout_en !== 1'b0) begin failures++; $display("FAIL wp_t3_en got=%b exp=0", bus.mem_dout_en); end
   endtask

   task automatic test_fifo_full;
      int accepted = 0;
      int issued   = 0;
      int outs     = 0;
      logic [18:0] ea;
      logic [35:0] ed;
      exp_q.delete();
      exp_data_q.delete();
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.vga_flag = 1'b1; bus.hcount = 10'd10; bus.vcount = 10'd3;
         bus.wr_valid = 1'b1;
         bus.wr_x = 9'(accepted); bus.wr_y = 9'(accepted + 1);
         bus.wr_data = 36'h100 + 36'(accepted);
         settle();
         if (bus.mem_we_b === 1'b0) issued++;
         if (bus.wr_ready === 1'b1) begin
            exp_q.push_back({1'b1, 9'(accepted + 1), 9'(accepted)});
            exp_data_q.push_back(36'h100 + 36'(accepted));
            accepted++;
         end
      end
      checks++; if (accepted !== 8) begin failures++; $display("FAIL ff_accepted got=%0d exp=8", accepted); end
      checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL ff_ready_full got=%b exp=0", bus.wr_ready); end
      checks++; if (issued !== 0) begin failures++; $display("FAIL ff_no_issue_under_reads got=%0d exp=0", issued); end
      issued = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         bus.wr_valid = 1'b0; bus.vga_flag = 1'b0;
         settle();
         if (bus.mem_we_b === 1'b0) begin
            issued++;
            ea = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
            checks++; if (bus.mem_addr !== ea) begin failures++; $display("FAIL ff_order_addr got=%h exp=%h", bus.mem_addr, ea); end
         end
         if (bus.mem_dout_en === 1'b1) begin
            outs++;
            ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 36'hFFFFFFFFF;
            checks++; if (bus.mem_dout !== ed) begin failures++; $display("FAIL ff_order_data got=%h exp=%h", bus.mem_dout, ed); end
         end
      end
      checks++; if (issued !== 8 || outs !== 8) begin failures++; $display("FAIL ff_drain_count got issued=%0d outs=%0d exp 8/8", issued, outs); end
   endtask

   task automatic test_swap;
      logic [18:0] e;
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.vga_flag = 1'b1; bus.hcount = 10'd4; bus.vcount = 10'd0;
         bus.wr_valid = 1'b1; bus.wr_x = 9'(20 + i); bus.wr_y = 9'd30; bus.wr_data = 36'h55 + 36'(i);
      end
      tick();
      bus.wr_valid = 1'b0; bus.frame_flag = 1'b1;
      tick();
      bus.frame_flag = 1'b0; bus.wr_valid = 1'b1; bus.wr_x = 9'd99; bus.wr_y = 9'd99;
      bus.hcount = 10'd0; bus.vcount = 10'd0;
      settle();
      checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL sw_ready_pending got=%b exp=0", bus.wr_ready); end
      checks++; if (bus.display_bank !== 1'b0 || bus.mem_addr[18] !== 1'b0) begin failures++; $display("FAIL sw_early got bank=%b msb=%b exp 0/0", bus.display_bank, bus.mem_addr[18]); end
      tick();
      bus.wr_valid = 1'b0; bus.vga_flag = 1'b0;
      settle();
      e = {1'b1, 9'd30, 9'd20};
      checks++; if (bus.mem_we_b !== 1'b0 || bus.mem_addr !== e) begin failures++; $display("FAIL sw_drain0 got we_b=%b addr=%h exp 0/%h", bus.mem_we_b, bus.mem_addr, e); end
      tick();
      bus.frame_flag = 1'b1;
      settle();
      e = {1'b1, 9'd30, 9'd21};
      checks++; if (bus.mem_we_b !== 1'b0 || bus.mem_addr !== e) begin failures++; $display("FAIL sw_drain1 got we_b=%b addr=%h exp 0/%h", bus.mem_we_b, bus.mem_addr, e); end
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.frame_flag = 1'b0; bus.vga_flag = 1'b1;
         settle();
         checks++; if (bus.display_bank !== 1'b0) begin failures++; $display("FAIL sw_wait_pipe got bank=%b exp=0", bus.display_bank); end
      end
      tick();
      settle();
      e = {1'b1, 9'd0, 9'd0};
      checks++; if (bus.display_bank !== 1'b1 || bus.mem_addr !== e) begin failures++; $display("FAIL sw_fire got bank=%b addr=%h exp 1/%h", bus.display_bank, bus.mem_addr, e); end
      tick();
      bus.vga_flag = 1'b0;
      settle();
      checks++; if (bus.display_bank !== 1'b1 || bus.wr_ready !== 1'b1 || bus.mem_we_b !== 1'b1) begin failures++; $display("FAIL sw_after got bank=%b ready=%b we_b=%b exp 1/1/1", bus.display_bank, bus.wr_ready, bus.mem_we_b); end
      tick();
      bus.vga_flag = 1'b1;
      settle();
      checks++; if (bus.display_bank !== 1'b1 || bus.mem_addr[18] !== 1'b1) begin failures++; $display("FAIL sw_no_double got bank=%b msb=%b exp 1/1", bus.display_bank, bus.mem_addr[18]); end
      tick();
      bus.vga_flag = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_midflight;
      int bad = 0;
      tick();
      bus.vga_flag = 1'b0; bus.wr_valid = 1'b1; bus.wr_x = 9'd1; bus.wr_y = 9'd2; bus.wr_data = 36'h111;
      tick();
      bus.wr_x = 9'd3; bus.wr_y = 9'd4; bus.wr_data = 36'h222;
      settle();
      checks++; if (bus.mem_we_b !== 1'b0) begin failures++; $display("FAIL rm_issue got we_b=%b exp=0", bus.mem_we_b); end
      tick();
      bus.wr_valid = 1'b0; bus.vga_flag = 1'b1; bus.hcount = 10'd2; bus.vcount = 10'd5;
      tick();
      bus.hcount = 10'd4;
      settle();
      checks++; if (bus.mem_dout_en !== 1'b1) begin failures++; $display("FAIL rm_pre_en got=%b exp=1", bus.mem_dout_en); end
      reset_b = 1'b0;
      #1;
      checks++; if (bus.mem_dout_en !== 1'b0 || bus.mem_dout !== 36'd0) begin failures++; $display("FAIL rm_async_dout got en=%b d=%h exp 0/0", bus.mem_dout_en, bus.mem_dout); end
      checks++; if (bus.done_vga !== 1'b0 || bus.vga_pixel !== 36'd0) begin failures++; $display("FAIL rm_async_read got done=%b pix=%h exp 0/0", bus.done_vga, bus.vga_pixel); end
      checks++; if (bus.display_bank !== 1'b0 || bus.wr_ready !== 1'b1) begin failures++; $display("FAIL rm_async_state got bank=%b ready=%b exp 0/1", bus.display_bank, bus.wr_ready); end
      checks++; if (bus.mem_addr !== 19'd0 || bus.mem_we_b !== 1'b1) begin failures++; $display("FAIL rm_async_bus got addr=%h we_b=%b exp 0/1", bus.mem_addr, bus.mem_we_b); end
      tick();
      tick();
      reset_b = 1'b1;
      bus.vga_flag = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.done_vga !== 1'b0 || bus.mem_dout_en !== 1'b0 || bus.mem_we_b !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rm_after_release got bad_cycles=%0d exp=0", bad); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_latency();
      test_write_priority();
      test_fifo_full();
      test_swap();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
